vga_timing_controller: RTL and testbench
========================================

// Module: vga_timing_controller
// PURPOSE
//  Master raster sequencer for the VGA output path. Divides the system clock down to the pixel
//  rate, runs the horizontal and vertical counters, and decodes from them HSync, VSync,
//  video_on, the pixel coordinates and frame/line markers. Pixel generators and the sync
//  output pins are driven from this block; it is the only owner of raster timing.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, in pixels
//  H_SYNC     96   HSync pulse width, in pixels
//  H_BACK     48   horizontal back porch, in pixels
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch, in lines
//  V_SYNC     2    VSync pulse width, in lines
//  V_BACK     33   vertical back porch, in lines
//  SYNC_POL   0    active level of HSync/VSync (0 = active-low)
// PORTS
//  clk          in   1   system clock; all logic is on the rising edge
//  reset        in   1   synchronous reset, active-high
//  enable       in   1   1 = raster runs; 0 = freeze the divider, the counters and all outputs
//  pixel_tick   out  1   one-clk pulse; the counters advance on the edge that ends this pulse
//  HSync        out  1   horizontal sync, registered
//  VSync        out  1   vertical sync, registered
//  video_on     out  1   1 while (pixel_x,pixel_y) lies inside the visible area
//  pixel_x      out  10  current horizontal count, 0..H_TOTAL-1
//  pixel_y      out  10  current vertical count, 0..V_TOTAL-1
//  line_start   out  1   one-clk pulse when pixel_x enters 0
//  frame_start  out  1   one-clk pulse when (pixel_x,pixel_y) enters (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of the four H params (800 by default); V_TOTAL likewise (525 by default).
//    Both must be <= 1024 (10-bit counters).
//  - Divider: div_cnt counts 0..CLK_DIV-1 while enable=1, then wraps to 0.
//    pixel_tick=1 for the clk cycle in which div_cnt==CLK_DIV-1 and enable=1.
//  - Horizontal counter: on an edge with pixel_tick=1, h = (h==H_TOTAL-1) ? 0 : h+1.
//  - Vertical counter: advances only on an edge where pixel_tick=1 and h==H_TOTAL-1.
//    v = (v==V_TOTAL-1) ? 0 : v+1.
//  - Decode and registration:
//    - All outputs except pixel_tick are registered.
//    - They are decoded from the next counter values, so each output is always consistent
//      with the pixel_x/pixel_y shown in the same cycle (zero lag between coordinates and sync).
//  - Decode rules:
//    - HSync = SYNC_POL while H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC
//      (656..751 by default); otherwise ~SYNC_POL.
//    - VSync = SYNC_POL while V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC
//      (490..491 by default); otherwise ~SYNC_POL.
//    - video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
//  - Markers:
//    - line_start=1 for exactly the clk cycle after the edge that set x to 0.
//    - frame_start=1 for exactly the clk cycle after the edge that set (x,y) to (0,0).
//      frame_start implies line_start.
//  - Reset values:
//    - div_cnt=0, pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524).
//    - HSync=VSync=~SYNC_POL (1), video_on=0, pixel_tick=0, line_start=0, frame_start=0.
//    - The first pixel_tick after reset therefore enters (0,0) and raises frame_start.
//  - enable=0:
//    - div_cnt and all counters hold; pixel_tick=0; the markers are forced to 0.
//    - HSync, VSync, video_on, pixel_x and pixel_y hold their values.
//    - Raising enable again resumes from the held div_cnt with no skipped pixel.
//  - reset overrides enable. reset mid-frame returns to the reset values on the next edge;
//    no partial line is completed.
//  - Latency: CLK_DIV clks per pixel. Line = H_TOTAL*CLK_DIV clks (3200).
//    Frame = H_TOTAL*V_TOTAL*CLK_DIV clks (1 680 000).
// TESTING
//  1. Reset for 3 clks, enable=1: the first pixel_tick occurs at the 4th clk.
//     Next cycle: pixel_x=0, pixel_y=0, video_on=1, frame_start=1, line_start=1.
//  2. Run one line: HSync=0 exactly while pixel_x is 656..751 (96 ticks = 384 clks);
//     video_on=0 from pixel_x=640 onward; pixel_x wraps 799->0 and pixel_y goes 0->1
//     on the same edge.
//  3. Run a full frame: VSync=0 only for pixel_y 490..491 (1600 ticks).
//     frame_start pulses are exactly 1 680 000 clks apart; line_start pulses 3200 clks apart.
//  4. Drop enable for 50 clks at pixel_x=300, then restore it: all outputs are frozen and
//     pixel_tick=0 while enable=0; the next tick after restore gives pixel_x=301.
//  5. Assert reset at pixel_y=200, pixel_x=400: the next cycle shows pixel_x=799,
//     pixel_y=524, HSync=VSync=1, video_on=0.
//  6. Instance with CLK_DIV=2 and SYNC_POL=1: pixel_tick every 2 clks;
//     HSync/VSync are high only inside their sync windows.

Source files
------------

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel-rate divider, horizontal/vertical counters and
// registered sync/visible/marker decode that always agrees with pixel_x/pixel_y.
module vga_timing_controller #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pixel_tick,
    output logic       HSync,
    output logic       VSync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hs_q, vs_q, von_q, ls_q, fs_q;
    logic             tick;

    function automatic logic hsync_level(input logic [9:0] x);
        if (int'(x) >= H_VISIBLE + H_FRONT && int'(x) < H_VISIBLE + H_FRONT + H_SYNC)
            return SYNC_ACT;
        return ~SYNC_ACT;
    endfunction

    function automatic logic vsync_level(input logic [9:0] y);
        if (int'(y) >= V_VISIBLE + V_FRONT && int'(y) < V_VISIBLE + V_FRONT + V_SYNC)
            return SYNC_ACT;
        return ~SYNC_ACT;
    endfunction

    function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
        return (int'(x) < H_VISIBLE) && (int'(y) < V_VISIBLE);
    endfunction

    // Next-state counters; decode below uses these so outputs line up with the coordinates.
    always_comb begin
        tick  = enable && !reset && (div_q == DIV_LAST);
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (enable)
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (tick) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
            if (h_q == H_LAST)
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            hs_q  <= ~SYNC_ACT;
            vs_q  <= ~SYNC_ACT;
            von_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hsync_level(h_d);
            vs_q  <= vsync_level(v_d);
            von_q <= visible(h_d, v_d);
            ls_q  <= tick && (h_d == 10'd0);
            fs_q  <= tick && (h_d == 10'd0) && (v_d == 10'd0);
        end
    end

    assign pixel_tick  = tick;
    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign video_on    = von_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench: stimulus queues hand-computed per-pixel expectations, monitors
// pop and compare on each new pixel; a second small-raster instance covers frame timing.
module tb_vga_timing_controller;

    typedef struct {
        int tick; int x; int y;
        bit hs; bit vs; bit von; bit ls; bit fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: default 640x480 timing
    logic       reset_a, en_a;
    logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_x, a_y;

    vga_timing_controller dut_a (
        .clk(clk), .reset(reset_a), .enable(en_a),
        .pixel_tick(a_tick), .HSync(a_hs), .VSync(a_vs), .video_on(a_von),
        .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    // Instance B: tiny raster 15x10, CLK_DIV=2, active-high syncs
    logic       reset_b, en_b;
    logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0] b_x, b_y;

    vga_timing_controller #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .enable(en_b),
        .pixel_tick(b_tick), .HSync(b_hs), .VSync(b_vs), .video_on(b_von),
        .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cmp_exp(input string p, input exp_t e, input int x, input int y,
                           input int hs, input int vs, input int von, input int ls, input int fs);
        check($sformatf("%s t%0d pixel_x", p, e.tick), x, e.x);
        check($sformatf("%s t%0d pixel_y", p, e.tick), y, e.y);
        check($sformatf("%s t%0d HSync", p, e.tick), hs, int'(e.hs));
        check($sformatf("%s t%0d VSync", p, e.tick), vs, int'(e.vs));
        check($sformatf("%s t%0d video_on", p, e.tick), von, int'(e.von));
        check($sformatf("%s t%0d line_start", p, e.tick), ls, int'(e.ls));
        check($sformatf("%s t%0d frame_start", p, e.tick), fs, int'(e.fs));
    endtask

    task automatic push_a(input int t, input int x, input int y, input bit hs, input bit vs,
                          input bit von, input bit ls, input bit fs);
        exp_t e;
        e = '{t, x, y, hs, vs, von, ls, fs};
        qa.push_back(e);
    endtask

    task automatic push_b(input int t, input int x, input int y, input bit hs, input bit vs,
                          input bit von, input bit ls, input bit fs);
        exp_t e;
        e = '{t, x, y, hs, vs, von, ls, fs};
        qb.push_back(e);
    endtask

    // Monitor A: reset values, freeze behaviour, and queued per-pixel expectations
    int tc_a = 0;
    bit rst_prev_a = 1'b0, tick_prev_a = 1'b0, en_prev_a = 1'b1;
    int sx, sy, shs, svs, svon;
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev_a) begin
            tc_a = 0;
            check("A reset pixel_x", int'(a_x), 799);
            check("A reset pixel_y", int'(a_y), 524);
            check("A reset HSync", int'(a_hs), 1);
            check("A reset VSync", int'(a_vs), 1);
            check("A reset video_on", int'(a_von), 0);
            check("A reset line_start", int'(a_ls), 0);
            check("A reset frame_start", int'(a_fs), 0);
        end else begin
            if (!en_prev_a) begin
                check("A frozen pixel_x", int'(a_x), sx);
                check("A frozen pixel_y", int'(a_y), sy);
                check("A frozen HSync", int'(a_hs), shs);
                check("A frozen VSync", int'(a_vs), svs);
                check("A frozen video_on", int'(a_von), svon);
                check("A frozen line_start", int'(a_ls), 0);
                check("A frozen frame_start", int'(a_fs), 0);
            end
            if (tick_prev_a) begin
                tc_a++;
                if (qa.size() > 0 && qa[0].tick == tc_a) begin
                    e = qa.pop_front();
                    cmp_exp("A", e, int'(a_x), int'(a_y), int'(a_hs), int'(a_vs),
                            int'(a_von), int'(a_ls), int'(a_fs));
                end
            end
        end
        if (!en_a && !reset_a) check("A pixel_tick while disabled", int'(a_tick), 0);
        sx = int'(a_x); sy = int'(a_y); shs = int'(a_hs); svs = int'(a_vs); svon = int'(a_von);
        rst_prev_a  = reset_a;
        tick_prev_a = a_tick;
        en_prev_a   = en_a;
    end

    // Monitor B: reset values, queued expectations, marker spacing
    int tc_b = 0, cyc_b = 0, last_ls_b = -1, last_fs_b = -1;
    bit rst_prev_b = 1'b0, tick_prev_b = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc_b++;
        if (rst_prev_b) begin
            tc_b = 0;
            last_ls_b = -1;
            last_fs_b = -1;
            check("B reset pixel_x", int'(b_x), 14);
            check("B reset pixel_y", int'(b_y), 9);
            check("B reset HSync", int'(b_hs), 0);
            check("B reset VSync", int'(b_vs), 0);
            check("B reset video_on", int'(b_von), 0);
        end else begin
            if (tick_prev_b) begin
                tc_b++;
                if (qb.size() > 0 && qb[0].tick == tc_b) begin
                    e = qb.pop_front();
                    cmp_exp("B", e, int'(b_x), int'(b_y), int'(b_hs), int'(b_vs),
                            int'(b_von), int'(b_ls), int'(b_fs));
                end
            end
            if (b_ls) begin
                if (last_ls_b >= 0) check("B line_start spacing", cyc_b - last_ls_b, 30);
                last_ls_b = cyc_b;
            end
            if (b_fs) begin
                if (last_fs_b >= 0) check("B frame_start spacing", cyc_b - last_fs_b, 300);
                last_fs_b = cyc_b;
            end
        end
        rst_prev_b  = reset_b;
        tick_prev_b = b_tick;
    end

    task automatic wait_a(input int x, input int y, input int limit, input string name);
        int n = 0;
        while (!(int'(a_x) == x && int'(a_y) == y) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_total++;
        if (n < limit) n_pass++;
        else $display("FAIL %s: got timeout after %0d clks, expected x=%0d y=%0d", name, n, x, y);
    endtask

    initial begin
        en_b = 1'b1;
        reset_b = 1'b1;
        push_b(1, 0, 0, 0, 0, 1, 1, 1);
        push_b(2, 1, 0, 0, 0, 1, 0, 0);
        push_b(8, 7, 0, 0, 0, 1, 0, 0);
        push_b(9, 8, 0, 0, 0, 0, 0, 0);
        push_b(10, 9, 0, 0, 0, 0, 0, 0);
        push_b(11, 10, 0, 1, 0, 0, 0, 0);
        push_b(13, 12, 0, 1, 0, 0, 0, 0);
        push_b(14, 13, 0, 0, 0, 0, 0, 0);
        push_b(15, 14, 0, 0, 0, 0, 0, 0);
        push_b(16, 0, 1, 0, 0, 1, 1, 0);
        push_b(91, 0, 6, 0, 0, 0, 1, 0);
        push_b(105, 14, 6, 0, 0, 0, 0, 0);
        push_b(106, 0, 7, 0, 1, 0, 1, 0);
        push_b(135, 14, 8, 0, 1, 0, 0, 0);
        push_b(136, 0, 9, 0, 0, 0, 1, 0);
        push_b(150, 14, 9, 0, 0, 0, 0, 0);
        push_b(151, 0, 0, 0, 0, 1, 1, 1);
        push_b(163, 12, 0, 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b0;
    end

    initial begin
        reset_a = 1'b1;
        en_a = 1'b1;
        push_a(1, 0, 0, 1, 1, 1, 1, 1);
        push_a(2, 1, 0, 1, 1, 1, 0, 0);
        push_a(640, 639, 0, 1, 1, 1, 0, 0);
        push_a(641, 640, 0, 1, 1, 0, 0, 0);
        push_a(656, 655, 0, 1, 1, 0, 0, 0);
        push_a(657, 656, 0, 0, 1, 0, 0, 0);
        push_a(752, 751, 0, 0, 1, 0, 0, 0);
        push_a(753, 752, 0, 1, 1, 0, 0, 0);
        push_a(800, 799, 0, 1, 1, 0, 0, 0);
        push_a(801, 0, 1, 1, 1, 1, 1, 0);
        push_a(802, 1, 1, 1, 1, 1, 0, 0);
        push_a(1101, 300, 1, 1, 1, 1, 0, 0);
        push_a(1102, 301, 1, 1, 1, 1, 0, 0);
        push_a(1103, 302, 1, 1, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset_a = 1'b0;

        wait_a(300, 1, 6000, "A reach x300");
        en_a = 1'b0;
        repeat (50) @(posedge clk);
        #1 en_a = 1'b1;

        wait_a(400, 1, 1000, "A reach x400");
        reset_a = 1'b1;
        push_a(1, 0, 0, 1, 1, 1, 1, 1);
        push_a(2, 1, 0, 1, 1, 1, 0, 0);
        @(posedge clk);
        #1 reset_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        check("A queue drained", qa.size(), 0);
        check("B queue drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

endmodule
